// File: rtl/hcordic_pkg.sv
// Shared definitions for the hyperbolic CORDIC vectoring engine:
// default widths, FSM encoding, repeated shift indices and the step count.
package hcordic_pkg;

   localparam int W_DEF    = 32;
   localparam int FRAC_DEF = 24;
   localparam int ITER_DEF = 16;

   // Width of the shift-index and step counters; covers ITER up to 39
   // (41 steps) with room for the index to run one past ITER.
   localparam int IDX_W = 6;

   // Shift indices that are executed twice for hyperbolic convergence.
   localparam int REP_IDX_A = 4;
   localparam int REP_IDX_B = 13;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   // Total micro-rotations for a given number of distinct shift indices.
   function automatic int hc_steps(input int iter);
      return (iter < REP_IDX_B) ? iter + 1 : iter + 2;
   endfunction

endpackage

// File: rtl/hcordic_atanh_rom.sv
// Constant table E[i] = round(atanh(2^-i) * 2^FRAC) for i = 1..ITER.
// Entries are computed at elaboration from the odd power series of atanh
// carried with 62 guard bits; index 0 and indices above ITER read as zero.
module hcordic_atanh_rom
   import hcordic_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int FRAC = FRAC_DEF,
   parameter int ITER = ITER_DEF
) (
   input  logic [IDX_W-1:0] idx_i,
   output logic [W-1:0]     e_o
);

   localparam int GB      = 62;
   localparam int N_ENTRY = 2 ** IDX_W;

   // atanh(2^-i) = sum over odd k of 2^(-i*k)/k, truncated per term at 2^-GB
   function automatic logic [W-1:0] atanh_pow2(input int i, input int frac);
      logic [63:0] acc;
      logic [63:0] term;
      acc = '0;
      for (int k = 1; i * k <= GB; k += 2) begin
         term = (64'd1 << (GB - i * k)) / 64'(k);
         acc  = acc + term;
      end
      acc = (acc + (64'd1 << (GB - frac - 1))) >> (GB - frac);
      return W'(acc);
   endfunction

   logic [W-1:0] tbl [0:N_ENTRY-1];

   for (genvar g = 0; g < N_ENTRY; g++) begin : g_rom
      if (g >= 1 && g <= ITER) begin : g_val
         localparam logic [W-1:0] EV = atanh_pow2(g, FRAC);
         assign tbl[g] = EV;
      end else begin : g_zero
         assign tbl[g] = '0;
      end
   end

   assign e_o = tbl[idx_i];

endmodule

// File: rtl/hcordic_vec_iter.sv
// Iterative hyperbolic CORDIC, vectoring mode. Drives Y towards zero and
// accumulates Z = atanh(Y0/X0) + Z0 using shift indices 1..ITER with 4 and
// 13 executed twice.
// Optional build macro HCORDIC_SHIFT_ROUND_EN: when defined, every shifted
// operand is rounded by adding the last bit shifted out; otherwise the
// shifts truncate. Timing and interface are the same in both builds.
//
// state | meaning
// IDLE  | ready for a request; START loads X0/Y0/Z0 and clears the counter
// RUN   | one micro-rotation per cycle until the last scheduled step
// FIN   | results settled; DONE is registered here and pulses next cycle
module hcordic_vec_iter
   import hcordic_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int FRAC = FRAC_DEF,
   parameter int ITER = ITER_DEF
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [W-1:0] x0_i,
   input  logic [W-1:0] y0_i,
   input  logic [W-1:0] z0_i,
   output logic         ready_o,
   output logic         done_o,
   output logic [W-1:0] x_o,
   output logic [W-1:0] y_o,
   output logic [W-1:0] z_o
);

   localparam int STEPS = hc_steps(ITER);

   state_e                state_q, state_d;
   logic signed [W-1:0]   x_q, x_d;
   logic signed [W-1:0]   y_q, y_d;
   logic signed [W-1:0]   z_q, z_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      cnt_q, cnt_d;
   logic                  rep_q, rep_d;
   logic                  done_q, done_d;

   logic                  step_last;
   logic                  is_rep_idx;
   logic                  d_pos;
   logic signed [W-1:0]   x_sh;
   logic signed [W-1:0]   y_sh;
   logic [W-1:0]          e_val;

   // Arithmetic right shift by the current index, optionally rounded.
   function automatic logic signed [W-1:0] shr(input logic signed [W-1:0] v,
                                               input logic [IDX_W-1:0] s);
      logic signed [W-1:0] t;
`ifdef HCORDIC_SHIFT_ROUND_EN
      logic signed [W-1:0] r1;
`endif
      t = v >>> s;
`ifdef HCORDIC_SHIFT_ROUND_EN
      // Shifting by s-1 also covers indices beyond W: the bit is then the sign.
      r1 = v >>> (s - 1'b1);
      t  = t + {{(W-1){1'b0}}, r1[0]};
`endif
      return t;
   endfunction

   hcordic_atanh_rom #(
      .W    (W),
      .FRAC (FRAC),
      .ITER (ITER)
   ) u_rom (
      .idx_i (idx_q),
      .e_o   (e_val)
   );

   assign x_sh       = shr(x_q, idx_q);
   assign y_sh       = shr(y_q, idx_q);
   assign d_pos      = y_q[W-1];
   assign step_last  = (cnt_q == IDX_W'(STEPS - 1));
   assign is_rep_idx = (idx_q == IDX_W'(REP_IDX_A)) || (idx_q == IDX_W'(REP_IDX_B));

   // Next-state, datapath update and step/index sequencing.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      rep_d   = rep_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               x_d     = x0_i;
               y_d     = y0_i;
               z_d     = z0_i;
               idx_d   = IDX_W'(1);
               cnt_d   = '0;
               rep_d   = 1'b0;
            end
         end
         ST_RUN: begin
            if (d_pos) begin
               x_d = x_q + y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - $signed(e_val);
            end else begin
               x_d = x_q - y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + $signed(e_val);
            end
            cnt_d = cnt_q + 1'b1;
            if (is_rep_idx && !rep_q) begin
               rep_d = 1'b1;
            end else begin
               rep_d = 1'b0;
               idx_d = idx_q + 1'b1;
            end
            if (step_last) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         rep_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         rep_q   <= rep_d;
         done_q  <= done_d;
      end
   end

   assign ready_o = (state_q == ST_IDLE);
   assign done_o  = done_q;
   assign x_o     = x_q;
   assign y_o     = y_q;
   assign z_o     = z_q;

endmodule

// File: tb/tb_hcordic_vec_iter.sv
// Directed bench for hcordic_vec_iter with default parameters
// (W=32, FRAC=24, ITER=16, 18 micro-rotations).
module tb_hcordic_vec_iter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [31:0] x0_i, y0_i, z0_i;
   logic        ready_o, done_o;
   logic [31:0] x_o, y_o, z_o;

   int total = 0;
   int bad   = 0;

   // Edges from the accept edge to the edge that raises DONE (18 steps + 1).
   localparam int LAT = 19;
   localparam int TOL = 1024;   // 2^-14 in Q7.24

   int etab [1:16] = '{9215828, 4285116, 2108178, 1049945, 524459, 262165,
                       131075, 65536, 32768, 16384, 8192, 4096, 2048, 1024,
                       512, 256};

   always #5 clk_i = ~clk_i;

   hcordic_vec_iter dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .x0_i    (x0_i),
      .y0_i    (y0_i),
      .z0_i    (z0_i),
      .ready_o (ready_o),
      .done_o  (done_o),
      .x_o     (x_o),
      .y_o     (y_o),
      .z_o     (z_o)
   );

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] msh(input logic [31:0] v, input int s);
      logic [31:0] t;
      t = $signed(v) >>> s;
`ifdef HCORDIC_SHIFT_ROUND_EN
      t = t + {31'd0, v[s-1]};
`endif
      return t;
   endfunction

   task automatic model(input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] z0,
                        output logic [31:0] xo, output logic [31:0] yo, output logic [31:0] zo);
      logic [31:0] x, y, z, xs, ys;
      int reps;
      x = x0; y = y0; z = z0;
      for (int i = 1; i <= 16; i++) begin
         reps = (i == 4 || i == 13) ? 2 : 1;
         for (int r = 0; r < reps; r++) begin
            xs = msh(x, i);
            ys = msh(y, i);
            if (y[31]) begin
               x = x + ys; y = y + xs; z = z - etab[i];
            end else begin
               x = x - ys; y = y - xs; z = z + etab[i];
            end
         end
      end
      xo = x; yo = y; zo = z;
   endtask

   function automatic logic [31:0] absdiff(input logic [31:0] a, input logic [31:0] b);
      int d;
      d = $signed(a) - $signed(b);
      return (d < 0) ? -d : d;
   endfunction

   task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      x0_i = a; y0_i = b; z0_i = c;
      start_i = 1'b1;
      tick;
      start_i = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick;
         n++;
      end while (done_o !== 1'b1 && n < 60);
   endtask

   logic [31:0] ex, ey, ez;
   int          n;
   int          rd_bad;
   int          dn_cnt;
   logic        seen;

   initial begin
      rst_i = 1'b1; start_i = 1'b1;
      x0_i = 32'h03B7E152; y0_i = 32'h01B7E152; z0_i = 32'h0;
      // reset held 3 cycles with START high: must not be accepted
      repeat (3) tick;
      rst_i = 1'b0; start_i = 1'b0;
      chk("rst_ready", {31'd0, ready_o}, 32'd1);
      chk("rst_done",  {31'd0, done_o},  32'd0);
      chk("rst_x", x_o, 32'd0);
      chk("rst_y", y_o, 32'd0);
      chk("rst_z", z_o, 32'd0);
      tick;
      chk("rst_idle_hold", {31'd0, ready_o}, 32'd1);

      // ln(e): Z -> 0.5
      model(32'h03B7E152, 32'h01B7E152, 32'h0, ex, ey, ez);
      accept(32'h03B7E152, 32'h01B7E152, 32'h0);
      chk("lne_ready_low", {31'd0, ready_o}, 32'd0);
      wait_done(n);
      chk("lne_latency", n, LAT);
      chk("lne_z_tol", {31'd0, absdiff(z_o, 32'h00800000) <= TOL}, 32'd1);
      chk("lne_z", z_o, ez);
      chk("lne_x", x_o, ex);
      chk("lne_y", y_o, ey);
      tick;
      chk("lne_done_pulse", {31'd0, done_o}, 32'd0);
      chk("lne_z_hold", z_o, ez);

      // a = 1: Y0 = 0 must rotate with d = -1 on the first step
      model(32'h02000000, 32'h0, 32'h0, ex, ey, ez);
      accept(32'h02000000, 32'h0, 32'h0);
      tick;
      chk("a1_step1_x", x_o, 32'h02000000);
      chk("a1_step1_y", y_o, 32'hFF000000);
      chk("a1_step1_z", z_o, 32'h008C9F54);
      wait_done(n);
      chk("a1_latency", n, LAT - 1);
      chk("a1_z_tol", {31'd0, absdiff(z_o, 32'h0) <= TOL}, 32'd1);
      chk("a1_y_tol", {31'd0, absdiff(y_o, 32'h0) <= TOL}, 32'd1);
      chk("a1_z", z_o, ez);
      chk("a1_y", y_o, ey);
      tick;

      // handshake: START at accept+5 and in FIN both ignored (a = 2)
      model(32'h03000000, 32'h01000000, 32'h0, ex, ey, ez);
      accept(32'h03000000, 32'h01000000, 32'h0);
      rd_bad = 0; dn_cnt = 0;
      for (int k = 1; k <= LAT; k++) begin
         start_i = (k == 5 || k == LAT);
         tick;
         if (k < LAT && ready_o !== 1'b0) rd_bad++;
         if (done_o === 1'b1) dn_cnt++;
      end
      start_i = 1'b0;
      chk("hs_ready_low", rd_bad, 0);
      chk("hs_done_at_lat", {31'd0, done_o}, 32'd1);
      chk("hs_z_tol", {31'd0, absdiff(z_o, 32'h0058B90C) <= TOL}, 32'd1);
      chk("hs_z", z_o, ez);
      for (int k = 0; k < 4; k++) begin
         tick;
         if (done_o === 1'b1) dn_cnt++;
      end
      chk("hs_one_done", dn_cnt, 1);
      chk("hs_no_accept", {31'd0, ready_o}, 32'd1);
      chk("hs_x_hold", x_o, ex);
      chk("hs_y_hold", y_o, ey);
      chk("hs_z_hold", z_o, ez);

      // reset mid-run at accept+7
      accept(32'h03B7E152, 32'h01B7E152, 32'h0);
      repeat (6) tick;
      rst_i = 1'b1;
      tick;
      rst_i = 1'b0;
      chk("mr_ready", {31'd0, ready_o}, 32'd1);
      chk("mr_done",  {31'd0, done_o},  32'd0);
      chk("mr_x", x_o, 32'd0);
      chk("mr_y", y_o, 32'd0);
      chk("mr_z", z_o, 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 25; k++) begin
         tick;
         if (done_o === 1'b1) seen = 1'b1;
      end
      chk("mr_no_done", {31'd0, seen}, 32'd0);

      model(32'h03B7E152, 32'h01B7E152, 32'h0, ex, ey, ez);
      accept(32'h03B7E152, 32'h01B7E152, 32'h0);
      wait_done(n);
      chk("mr_lne_latency", n, LAT);
      chk("mr_lne_z", z_o, ez);
      chk("mr_lne_z_tol", {31'd0, absdiff(z_o, 32'h00800000) <= TOL}, 32'd1);
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
